// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: valid/ready byte handshakes from two requesters into uart_tx_ctrl
interface uart_tx_ctrl_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  modport master (output req0_valid, req0_data, req1_valid, req1_data, input req0_ready, req1_ready);
  modport slave (input req0_valid, req0_data, req1_valid, req1_data, output req0_ready, req1_ready);
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: round-robin two-requester UART TX frame sequencer driving tx_en/din/bit_cnto.
// Define UART_TX_CTRL_STOP2_EN for two stop bits (adds the STOP2 state).
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_ctrl_if.slave req,
  output logic          tx_en_o,
  output logic [7:0]    din_o,
  output logic [9:0]    bit_cnto_o,
  output logic          busy_o,
  output logic          grant_o,
  output logic          done_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef UART_TX_CTRL_STOP2_EN
  typedef enum logic [1:0] {IDLE, SEND, STOP2} state_t;
`else
  typedef enum logic [0:0] {IDLE, SEND} state_t;
`endif
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    din_q, din_d;
  logic          grant_q, grant_d, ptr_q, ptr_d, done_q, done_d;
  logic          idle, sel, acc, wrap;
  assign idle = state_q == IDLE;
  // With both valid the pointer decides; otherwise the lone requester wins
  assign sel  = (req.req0_valid & req.req1_valid) ? ptr_q : req.req1_valid;
  assign acc  = idle & (req.req0_valid | req.req1_valid);
  assign wrap = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign req.req0_ready = acc & ~sel;
  assign req.req1_ready = acc & sel;
  assign tx_en_o    = ~idle;
  assign busy_o     = ~idle;
  assign din_o      = din_q;
  assign bit_cnto_o = {6'd0, bit_q};
  assign grant_o    = grant_q;
  assign done_o     = done_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    din_d   = din_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    if (acc) begin
      state_d = SEND;
      cnt_d   = '0;
      bit_d   = '0;
      din_d   = sel ? req.req1_data : req.req0_data;
      grant_d = sel;
      ptr_d   = ~sel;
    end else if (!idle) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      if (wrap && bit_q == 4'd9) begin
`ifdef UART_TX_CTRL_STOP2_EN
        state_d = (state_q == SEND) ? STOP2 : IDLE;
        bit_d   = (state_q == SEND) ? bit_q : 4'd0;
        done_d  = state_q == STOP2;
`else
        state_d = IDLE;
        bit_d   = '0;
        done_d  = 1'b1;
`endif
      end else if (wrap) begin
        bit_d = bit_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      din_q   <= '0;
      grant_q <= 1'b0;
      ptr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      din_q   <= din_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: frame-timeline model of uart_tx_ctrl checked every cycle, plus literal spot checks.
module tb_uart_tx_ctrl;
  localparam int C = 4;
`ifdef UART_TX_CTRL_STOP2_EN
  localparam int NB = 11;
  localparam int DONE_LIT = 44;
`else
  localparam int NB = 10;
  localparam int DONE_LIT = 40;
`endif
  localparam int FL = NB * C;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_en, busy, grant, done;
  logic [7:0] din;
  logic [9:0] bit_cnto;
  int         total = 0;
  int         bad = 0;
  uart_tx_ctrl_if bus();
  uart_tx_ctrl #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .req(bus), .tx_en_o(tx_en), .din_o(din),
    .bit_cnto_o(bit_cnto), .busy_o(busy), .grant_o(grant), .done_o(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Round robin: the favoured requester wins if valid, else the other one; -1 means nobody
  function automatic int pick(input logic v0, input logic v1, input logic p);
    logic [1:0] v;
    v = {v1, v0};
    if (v[p]) return int'(p);
    if (v[!p]) return int'(!p);
    return -1;
  endfunction
  // Serial line the datapath would emit for a given bit index and byte
  function automatic logic line(input logic [9:0] b, input logic [7:0] d);
    if (b == 10'd0) return 1'b0;
    if (b >= 10'd9) return 1'b1;
    return d[b[2:0] - 3'd1];
  endfunction
  int         cyc, m_start, m_pick;
  logic       m_act, m_done, m_grant, m_ptr;
  logic [7:0] m_din;
  always_comb m_pick = pick(bus.req0_valid, bus.req1_valid, m_ptr);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc <= 0; m_start <= 0; m_act <= 1'b0; m_done <= 1'b0;
      m_grant <= 1'b0; m_ptr <= 1'b0; m_din <= 8'h00;
    end else begin
      cyc <= cyc + 1;
      m_done <= m_act && (cyc + 1 - m_start == FL);
      if (!m_act && m_pick >= 0) begin
        m_act   <= 1'b1;
        m_start <= cyc + 1;
        m_grant <= m_pick == 1;
        m_ptr   <= m_pick == 0;
        m_din   <= (m_pick == 1) ? bus.req1_data : bus.req0_data;
      end else if (m_act && cyc + 1 - m_start == FL) begin
        m_act <= 1'b0;
      end
    end
  end
  function automatic int exp_bit();
    int b;
    b = (cyc - m_start) / C;
    return m_act ? (b > 9 ? 9 : b) : 0;
  endfunction
  always @(negedge clk) begin
    if (!rst) begin
      chk("tx_en", int'(tx_en), int'(m_act));
      chk("busy", int'(busy), int'(m_act));
      chk("bit_cnto", int'(bit_cnto), exp_bit());
      chk("din", int'(din), int'(m_din));
      chk("grant", int'(grant), int'(m_grant));
      chk("done", int'(done), int'(m_done));
      chk("ready0", int'(bus.req0_ready), int'(!m_act && m_pick == 0));
      chk("ready1", int'(bus.req1_ready), int'(!m_act && m_pick == 1));
    end
  end
  int   e;
  logic lit [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  task automatic step_to(input int n);
    int g;
    g = 0;
    while (cyc - e < n && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) chk("step_timeout", cyc - e, n);
  endtask
  initial begin
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.req0_data = 8'h00; bus.req1_data = 8'h00;
    e = 0;
    #1 rst = 1'b1;
    #1;
    chk("rst_tx_en", int'(tx_en), 0);
    chk("rst_bit", int'(bit_cnto), 0);
    chk("rst_din", int'(din), 0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_data = 8'hA5;
    @(negedge clk);
    e = cyc;
    chk("t1_tx_en", int'(tx_en), 1);
    chk("t1_din", int'(din), 8'hA5);
    #1 bus.req0_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step_to(k * C + 1);
      chk("t1_bit", int'(bit_cnto), k);
      chk("t1_line", int'(line(bit_cnto, din)), int'(lit[k]));
    end
    begin
      int g;
      g = 0;
      while (!done && g < 100) begin
        @(negedge clk);
        g++;
      end
    end
    chk("t1_done_at", cyc - e, DONE_LIT);
    chk("t1_grant", int'(grant), 0);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_data = 8'h11;
    bus.req1_valid = 1'b1; bus.req1_data = 8'h22;
    @(negedge clk);
    e = cyc;
    chk("t2_din_a", int'(din), 8'h11);
    chk("t2_grant_a", int'(grant), 0);
    step_to(FL);
    chk("t2_gap", int'(tx_en), 0);
    step_to(FL + 1);
    chk("t2_din_b", int'(din), 8'h22);
    chk("t2_grant_b", int'(grant), 1);
    chk("t2_bit_b", int'(bit_cnto), 0);
    e = cyc;
    step_to(FL + 1);
    chk("t2_din_c", int'(din), 8'h11);
    chk("t2_grant_c", int'(grant), 0);
    e = cyc;
    #1 bus.req0_valid = 1'b0; bus.req1_data = 8'h77;
    step_to(FL + 1);
    chk("t3_grant_a", int'(grant), 1);
    chk("t3_din_a", int'(din), 8'h77);
    e = cyc;
    step_to(FL + 1);
    chk("t3_grant_b", int'(grant), 1);
    chk("t3_tx_en_b", int'(tx_en), 1);
    e = cyc;
    #1 bus.req1_valid = 1'b0;
    step_to(FL + 2);
    #1 bus.req0_valid = 1'b1; bus.req0_data = 8'h5A;
    @(negedge clk);
    e = cyc;
    step_to(17);
    #1 rst = 1'b1;
    #1;
    chk("t4_tx_en", int'(tx_en), 0);
    chk("t4_bit", int'(bit_cnto), 0);
    chk("t4_din", int'(din), 0);
    chk("t4_busy", int'(busy), 0);
    chk("t4_done", int'(done), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    e = cyc;
    chk("t4_restart_bit", int'(bit_cnto), 0);
    chk("t4_restart_din", int'(din), 8'h5A);
    #1 bus.req0_valid = 1'b0;
    step_to(FL + 2);
    #1 bus.req0_valid = 1'b1; bus.req0_data = 8'h3C;
    @(negedge clk);
    e = cyc;
    #1 bus.req0_data = 8'hFF; bus.req1_valid = 1'b1; bus.req1_data = 8'h99;
    step_to(20);
    chk("t5_din", int'(din), 8'h3C);
    chk("t5_ready0", int'(bus.req0_ready), 0);
    chk("t5_ready1", int'(bus.req1_ready), 0);
    #1 bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    step_to(FL + 2);
    chk("t5_din_hold", int'(din), 8'h3C);
    chk("t5_idle", int'(tx_en), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
